// File: rtl/fwrisc_trace_pkg.sv
// Shared definitions for the fwrisc trace arbiter: record kinds, record
// layout and source indices.
package fwrisc_trace_pkg;

  localparam logic [1:0] KIND_INSTR = 2'd0;
  localparam logic [1:0] KIND_REG   = 2'd1;
  localparam logic [1:0] KIND_MEM   = 2'd2;

  // Record layout, LSB first: strb[3:0], b[35:4], a[67:36], ts[99:68], kind[101:100]
  localparam int REC_W    = 102;
  localparam int STRB_LSB = 0;
  localparam int B_LSB    = 4;
  localparam int A_LSB    = 36;
  localparam int TS_LSB   = 68;
  localparam int KIND_LSB = 100;

  // Slot indices double as arbitration priority (lower index wins)
  localparam int N_SRC     = 3;
  localparam int SRC_INSTR = 0;
  localparam int SRC_REG   = 1;
  localparam int SRC_MEM   = 2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] ts;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  strb;
  } trace_rec_t;

  function automatic trace_rec_t make_rec(input logic [1:0]  kind,
                                          input logic [31:0] ts,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  strb);
    trace_rec_t r;
    r.kind = kind;
    r.ts   = ts;
    r.a    = a;
    r.b    = b;
    r.strb = strb;
    return r;
  endfunction

endpackage

// File: rtl/fwrisc_trace_fifo.sv
// Synchronous FIFO holding trace records. DEPTH must be a power of two so the
// pointers wrap naturally. Storage is cleared on reset so an empty FIFO
// presents an all-zero head.
module fwrisc_trace_fifo #(
  parameter int WIDTH = 102,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Next-state: write at tail, advance pointers, track occupancy
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: storage is reset too, because the head is visible on the outputs even when empty.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fwrisc_trace_arbiter.sv
// Merges instruction-retire, register-write and memory-write trace events
// into one handshaked stream. Each source has a one-deep capture slot; a
// fixed-priority arbiter moves one slot per cycle into the FIFO. Events that
// arrive while their slot is still occupied are counted as drops.
module fwrisc_trace_arbiter
  import fwrisc_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en_instr,
  input  logic                   en_reg,
  input  logic                   en_mem,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr,
  input  logic                   ivalid,
  input  logic [5:0]             rd_waddr,
  input  logic [31:0]            rd_wdata,
  input  logic                   rd_write,
  input  logic [31:0]            maddr,
  input  logic [31:0]            mdata,
  input  logic [3:0]             mstrb,
  input  logic                   mwrite,
  input  logic                   mvalid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_kind,
  output logic [31:0]            out_ts,
  output logic [31:0]            out_a,
  output logic [31:0]            out_b,
  output logic [3:0]             out_strb,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_count
);

  logic [31:0]       ts_q, ts_d;
  logic [N_SRC-1:0]  slot_full_q, slot_full_d;
  trace_rec_t        slot_q [N_SRC];
  trace_rec_t        slot_d [N_SRC];
  trace_rec_t        new_rec [N_SRC];
  logic [N_SRC-1:0]  cap;
  logic [N_SRC-1:0]  grant;
  trace_rec_t        push_rec;
  trace_rec_t        head;
  logic [REC_W-1:0]  fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [1:0]        n_drop;
  logic [DROP_W:0]   drop_sum;

  // Capture qualifiers and the records each source would load this cycle
  always_comb begin
    cap[SRC_INSTR]     = ivalid && en_instr;
    cap[SRC_REG]       = rd_write && en_reg && (rd_waddr != 6'd0);
    cap[SRC_MEM]       = mvalid && mwrite && en_mem;
    new_rec[SRC_INSTR] = make_rec(KIND_INSTR, ts_q, pc, instr, 4'h0);
    new_rec[SRC_REG]   = make_rec(KIND_REG, ts_q, {26'd0, rd_waddr}, rd_wdata, 4'h0);
    new_rec[SRC_MEM]   = make_rec(KIND_MEM, ts_q, maddr, mdata, mstrb);
  end

  // Fixed-priority grant; nothing moves while the FIFO is full, even if it pops
  always_comb begin
    grant    = '0;
    push_rec = '0;
    if (!fifo_full) begin
      if (slot_full_q[SRC_INSTR]) begin
        grant[SRC_INSTR] = 1'b1;
        push_rec         = slot_q[SRC_INSTR];
      end else if (slot_full_q[SRC_REG]) begin
        grant[SRC_REG] = 1'b1;
        push_rec       = slot_q[SRC_REG];
      end else if (slot_full_q[SRC_MEM]) begin
        grant[SRC_MEM] = 1'b1;
        push_rec       = slot_q[SRC_MEM];
      end
    end
  end

  // Slot update, drop accounting and timestamp advance
  always_comb begin
    ts_d   = ts_q + 32'd1;
    n_drop = 2'd0;
    for (int i = 0; i < N_SRC; i++) begin
      slot_full_d[i] = slot_full_q[i];
      slot_d[i]      = slot_q[i];
      if (cap[i] && (!slot_full_q[i] || grant[i])) begin
        slot_full_d[i] = 1'b1;
        slot_d[i]      = new_rec[i];
      end else if (cap[i]) begin
        n_drop = n_drop + 2'd1;
      end else if (grant[i]) begin
        slot_full_d[i] = 1'b0;
      end
    end
    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
    drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q        <= '0;
      slot_full_q <= '0;
      drop_q      <= '0;
      for (int i = 0; i < N_SRC; i++) slot_q[i] <= '0;
    end else begin
      ts_q        <= ts_d;
      slot_full_q <= slot_full_d;
      drop_q      <= drop_d;
      for (int i = 0; i < N_SRC; i++) slot_q[i] <= slot_d[i];
    end
  end

  fwrisc_trace_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (|grant),
    .wdata(push_rec),
    .full (fifo_full),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .empty(fifo_empty),
    .level(level)
  );

  assign head       = trace_rec_t'(fifo_rdata);
  assign out_valid  = !fifo_empty;
  assign fifo_pop   = out_valid && out_ready;
  assign out_kind   = head.kind;
  assign out_ts     = head.ts;
  assign out_a      = head.a;
  assign out_b      = head.b;
  assign out_strb   = head.strb;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fwrisc_trace_arbiter.sv
// Directed testbench for fwrisc_trace_arbiter. Inputs change and outputs are
// sampled on the falling edge; cyc counts cycles since the last reset release,
// so it equals the timestamp a capture in the current cycle should carry.
module tb_fwrisc_trace_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en_instr, en_reg, en_mem;
  logic [31:0] pc, instr;
  logic        ivalid;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_write;
  logic [31:0] maddr, mdata;
  logic [3:0]  mstrb;
  logic        mwrite, mvalid;
  logic        out_valid, out_ready;
  logic [1:0]  out_kind;
  logic [31:0] out_ts, out_a, out_b;
  logic [3:0]  out_strb;
  logic [3:0]  level;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  fwrisc_trace_arbiter #(.DEPTH(8), .DROP_W(16)) dut (
    .clock(clock), .reset(reset),
    .en_instr(en_instr), .en_reg(en_reg), .en_mem(en_mem),
    .pc(pc), .instr(instr), .ivalid(ivalid),
    .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_write(rd_write),
    .maddr(maddr), .mdata(mdata), .mstrb(mstrb), .mwrite(mwrite), .mvalid(mvalid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_ts(out_ts), .out_a(out_a), .out_b(out_b),
    .out_strb(out_strb), .level(level), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle();
    ivalid = 0; rd_write = 0; mvalid = 0; mwrite = 0;
    pc = 0; instr = 0; rd_waddr = 0; rd_wdata = 0;
    maddr = 0; mdata = 0; mstrb = 0;
  endtask

  task automatic do_reset();
    idle();
    en_instr = 1; en_reg = 1; en_mem = 1; out_ready = 0;
    @(negedge clock);
    reset = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h expected 0", out_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", drop_count); end
    checks++; if ({out_kind, out_ts, out_a, out_b, out_strb} !== 102'd0) begin
      errors++; $display("FAIL rst_payload: got kind %0h ts %0h a %0h b %0h strb %0h expected all 0",
                         out_kind, out_ts, out_a, out_b, out_strb);
    end
  endtask

  task automatic test_single_reg();
    do_reset();
    out_ready = 1;
    repeat (10) step();
    rd_write = 1; rd_waddr = 6'd5; rd_wdata = 32'hDEADBEEF;
    step();
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c11_valid: got %0h expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_c12_valid: got %0h expected 1", out_valid); end
    checks++; if (out_kind !== 2'd1) begin errors++; $display("FAIL reg_kind: got %0d expected 1", out_kind); end
    checks++; if (out_ts !== 32'd10) begin errors++; $display("FAIL reg_ts: got %0d expected 10", out_ts); end
    checks++; if (out_a !== 32'd5) begin errors++; $display("FAIL reg_a: got %0h expected 5", out_a); end
    checks++; if (out_b !== 32'hDEADBEEF) begin errors++; $display("FAIL reg_b: got %0h expected deadbeef", out_b); end
    checks++; if (out_strb !== 4'h0) begin errors++; $display("FAIL reg_strb: got %0h expected 0", out_strb); end
    step();
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL reg_popped: got valid %0h level %0d expected 0 0", out_valid, level);
    end
  endtask

  task automatic test_three_sources();
    int c0;
    logic [1:0]  exp_kind [3];
    logic [31:0] exp_a [3];
    logic [31:0] exp_b [3];
    logic [3:0]  exp_s [3];
    exp_kind = '{2'd0, 2'd1, 2'd2};
    exp_a    = '{32'h100, 32'd7, 32'h2000};
    exp_b    = '{32'h13, 32'h1234, 32'hCAFEF00D};
    exp_s    = '{4'h0, 4'h0, 4'h6};
    do_reset();
    out_ready = 1;
    repeat (3) step();
    c0 = cyc;
    ivalid = 1; pc = 32'h100; instr = 32'h13;
    rd_write = 1; rd_waddr = 6'd7; rd_wdata = 32'h1234;
    mvalid = 1; mwrite = 1; maddr = 32'h2000; mdata = 32'hCAFEF00D; mstrb = 4'b0110;
    step();
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tri_early: got %0h expected 0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_kind !== exp_kind[k] || out_ts !== 32'(c0) ||
          out_a !== exp_a[k] || out_b !== exp_b[k] || out_strb !== exp_s[k]) begin
        errors++;
        $display("FAIL tri_rec%0d: got v%0h k%0d ts%0d a%0h b%0h s%0h expected v1 k%0d ts%0d a%0h b%0h s%0h",
                 k, out_valid, out_kind, out_ts, out_a, out_b, out_strb,
                 exp_kind[k], c0, exp_a[k], exp_b[k], exp_s[k]);
      end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tri_done: got %0h expected 0", out_valid); end
  endtask

  task automatic test_zero_waddr();
    do_reset();
    out_ready = 1;
    rd_write = 1; rd_waddr = 6'd0; rd_wdata = 32'h55;
    step();
    en_reg = 0; rd_waddr = 6'd3;
    step();
    idle(); en_reg = 1;
    repeat (3) step();
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL zero_waddr_rec: got valid %0h level %0d expected 0 0", out_valid, level);
    end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL zero_waddr_drop: got %0d expected 0", drop_count); end
  endtask

  task automatic fill_twelve();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      ivalid = 1; pc = 32'h1000 + 32'(4 * k); instr = 32'(k);
      step();
    end
    idle();
  endtask

  task automatic test_back_to_back();
    fill_twelve();
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL bp_level: got %0d expected 8", level); end
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL bp_drop: got %0d expected 3", drop_count); end
    step();
    checks++; if (out_pc_head() !== 32'h1000) begin errors++; $display("FAIL bp_head_stable: got %0h expected 1000", out_a); end
    out_ready = 1;
    for (int j = 0; j < 9; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_a !== 32'h1000 + 32'(4 * j) || out_ts !== 32'(j) || out_b !== 32'(j)) begin
        errors++;
        $display("FAIL bp_drain%0d: got v%0h a%0h ts%0d b%0h expected v1 a%0h ts%0d b%0h",
                 j, out_valid, out_a, out_ts, out_b, 32'h1000 + 32'(4 * j), j, j);
      end
      step();
    end
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL bp_empty: got valid %0h level %0d expected 0 0", out_valid, level);
    end
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL bp_drop_after: got %0d expected 3", drop_count); end
  endtask

  function automatic logic [31:0] out_pc_head();
    return out_a;
  endfunction

  task automatic test_reset_mid_drain();
    fill_twelve();
    out_ready = 1;
    repeat (4) step();
    out_ready = 0;
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL mid_level: got %0d expected 5", level); end
    reset = 0;
    @(posedge clock);
    @(negedge clock);
    checks++; if (out_valid !== 1'b0 || level !== 4'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL mid_reset: got valid %0h level %0d drop %0d expected 0 0 0",
                         out_valid, level, drop_count);
    end
    reset = 1;
    cyc = 0;
    ivalid = 1; pc = 32'hABC; instr = 32'h77;
    step();
    idle();
    step();
    checks++; if (out_valid !== 1'b1 || out_ts !== 32'd0 || out_a !== 32'hABC) begin
      errors++; $display("FAIL mid_resume: got valid %0h ts %0d a %0h expected 1 0 abc", out_valid, out_ts, out_a);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      ivalid = 1; pc = 32'(k);
      step();
    end
    idle();
    rd_write = 1; rd_waddr = 6'd1; rd_wdata = 32'h1;
    mvalid = 1; mwrite = 1; maddr = 32'h40;
    step();
    checks++; if (level !== 4'd8 || drop_count !== 16'd0) begin
      errors++; $display("FAIL sat_setup: got level %0d drop %0d expected 8 0", level, drop_count);
    end
    ivalid = 1;
    repeat (21844) step();
    checks++; if (drop_count !== 16'd65532) begin errors++; $display("FAIL sat_bulk: got %0d expected 65532", drop_count); end
    mvalid = 0;
    step();
    checks++; if (drop_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %0h expected fffe", drop_count); end
    mvalid = 1;
    step();
    checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_three: got %0h expected ffff", drop_count); end
    step();
    checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffff", drop_count); end
    idle();
  endtask

  initial begin
    idle();
    en_instr = 1; en_reg = 1; en_mem = 1; out_ready = 0;
    test_reset();
    test_single_reg();
    test_three_sources();
    test_zero_waddr();
    test_back_to_back();
    test_reset_mid_drain();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
